// File: rtl/sdrc_pkg.sv
// rtl/sdrc_pkg.sv - shared SDRAM controller command codes and widths
package sdrc_pkg;

  localparam logic [1:0] OP_PRE = 2'b00;
  localparam logic [1:0] OP_ACT = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_WR  = 2'b11;

  localparam int SDR_REQ_ID_W = 4;
  localparam int REQ_BW       = 12;

  function automatic logic is_xfer(input logic [1:0] cmd);
    return (cmd == OP_RD) || (cmd == OP_WR);
  endfunction

endpackage

// File: rtl/sdrc_rank_fifo.sv
// rtl/sdrc_rank_fifo.sv - FIFO of bank indices in request acceptance order
module sdrc_rank_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic [1:0]  push_data,
  input  logic        pop,
  output logic [1:0]  head,
  output logic        full,
  output logic [AW:0] count,
  output logic        ovf
);

  logic [DEPTH-1:0][1:0] mem_q, mem_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  full_q, full_d;
  logic                  do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A pop frees the slot in the same cycle, so push while full is legal then
    do_push  = push && (!full_q || do_pop);
    ovf      = push && !do_push;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    full_d  = (count_d == (AW+1)'(DEPTH));
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign count = count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

endmodule

// File: rtl/sdrc_bank_arb.sv
// rtl/sdrc_bank_arb.sv - bank command arbiter: in-order RD/WR, round-robin PRE/ACT
module sdrc_bank_arb #(
  parameter int NBANK      = 4,
  parameter int RANK_DEPTH = 4,
  parameter int REQ_BW     = sdrc_pkg::REQ_BW,
  parameter int ID_W       = sdrc_pkg::SDR_REQ_ID_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NBANK-1:0]        bnk_req,
  input  logic [2*NBANK-1:0]      bnk_cmd,
  input  logic [13*NBANK-1:0]     bnk_addr,
  input  logic [ID_W*NBANK-1:0]   bnk_id,
  input  logic [REQ_BW*NBANK-1:0] bnk_len,
  input  logic [NBANK-1:0]        bnk_start,
  input  logic [NBANK-1:0]        bnk_last,
  input  logic [NBANK-1:0]        bnk_wrap,
  input  logic [NBANK-1:0]        bnk_r2b_ack,
  output logic [NBANK-1:0]        bnk_ack,
  output logic                    rank_full,
  output logic                    rank_err,
  output logic                    b2x_req,
  output logic [1:0]              b2x_ba,
  output logic [1:0]              b2x_cmd,
  output logic [12:0]             b2x_addr,
  output logic [ID_W-1:0]         b2x_id,
  output logic [REQ_BW-1:0]       b2x_len,
  output logic                    b2x_start,
  output logic                    b2x_last,
  output logic                    b2x_wrap,
  input  logic                    x2b_ack
);

  import sdrc_pkg::*;

  localparam int CW = $clog2(RANK_DEPTH) + 1;

  logic [1:0]    rank_head, gnt_bank, idx, push_idx;
  logic [1:0]    rr_q, rr_d;
  logic          rank_err_q, rank_err_d;
  logic [CW-1:0] rank_cnt;
  logic          rank_empty, rank_push, rank_pop, rank_ovf, multi_ack;
  logic          gnt_vld, acked;

  assign rank_empty = (rank_cnt == '0);

  // Grant is combinational: bank FSMs expect their ack in the requesting cycle
  always_comb begin
    gnt_bank = 2'd0;
    gnt_vld  = 1'b0;
    idx      = 2'd0;
    if (!rank_empty && bnk_req[rank_head] && is_xfer(bnk_cmd[2*rank_head +: 2])) begin
      gnt_bank = rank_head;
      gnt_vld  = 1'b1;
    end else begin
      for (int k = 0; k < NBANK; k++) begin
        idx = rr_q + 2'(k);
        if (!gnt_vld && bnk_req[idx] && !is_xfer(bnk_cmd[2*idx +: 2])) begin
          gnt_bank = idx;
          gnt_vld  = 1'b1;
        end
      end
    end
    if (!reset_n) begin
      gnt_vld  = 1'b0;
      gnt_bank = 2'd0;
    end
  end

  assign b2x_req   = gnt_vld;
  assign b2x_ba    = gnt_bank;
  assign b2x_cmd   = bnk_cmd[2*gnt_bank +: 2];
  assign b2x_addr  = bnk_addr[13*gnt_bank +: 13];
  assign b2x_id    = bnk_id[ID_W*gnt_bank +: ID_W];
  assign b2x_len   = bnk_len[REQ_BW*gnt_bank +: REQ_BW];
  assign b2x_start = bnk_start[gnt_bank];
  assign b2x_last  = bnk_last[gnt_bank];
  assign b2x_wrap  = bnk_wrap[gnt_bank];

  assign acked    = gnt_vld && x2b_ack;
  assign bnk_ack  = acked ? ({{(NBANK-1){1'b0}}, 1'b1} << gnt_bank) : '0;
  assign rank_pop = acked && is_xfer(b2x_cmd) && b2x_last;

  always_comb begin
    push_idx = 2'd0;
    for (int i = NBANK - 1; i >= 0; i--) begin
      if (bnk_r2b_ack[i]) push_idx = 2'(i);
    end
  end

  assign rank_push = |bnk_r2b_ack;
  assign multi_ack = (bnk_r2b_ack & (bnk_r2b_ack - 1'b1)) != '0;

  always_comb begin
    rr_d       = rr_q;
    rank_err_d = rank_err_q || multi_ack || rank_ovf;
    if (acked && !is_xfer(b2x_cmd)) rr_d = gnt_bank + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_q       <= 2'd0;
      rank_err_q <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      rank_err_q <= rank_err_d;
    end
  end

  assign rank_err = rank_err_q;

  sdrc_rank_fifo #(.DEPTH(RANK_DEPTH)) u_rank_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rank_push),
    .push_data (push_idx),
    .pop       (rank_pop),
    .head      (rank_head),
    .full      (rank_full),
    .count     (rank_cnt),
    .ovf       (rank_ovf)
  );

endmodule

// File: tb/tb_sdrc_bank_arb.sv
// tb/tb_sdrc_bank_arb.sv - scoreboard bench for sdrc_bank_arb against a queue model
module tb_sdrc_bank_arb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  bnk_req = '0;
  logic [7:0]  bnk_cmd = '0;
  logic [51:0] bnk_addr = '0;
  logic [15:0] bnk_id = '0;
  logic [47:0] bnk_len = '0;
  logic [3:0]  bnk_start = '0, bnk_last = '0, bnk_wrap = '0, bnk_r2b_ack = '0;
  logic        x2b_ack = 1'b0;
  logic [3:0]  bnk_ack;
  logic        rank_full, rank_err, b2x_req;
  logic [1:0]  b2x_ba, b2x_cmd;
  logic [12:0] b2x_addr;
  logic [3:0]  b2x_id;
  logic [11:0] b2x_len;
  logic        b2x_start, b2x_last, b2x_wrap;

  sdrc_bank_arb dut (
    .clk(clk), .reset_n(reset_n), .bnk_req(bnk_req), .bnk_cmd(bnk_cmd),
    .bnk_addr(bnk_addr), .bnk_id(bnk_id), .bnk_len(bnk_len),
    .bnk_start(bnk_start), .bnk_last(bnk_last), .bnk_wrap(bnk_wrap),
    .bnk_r2b_ack(bnk_r2b_ack), .bnk_ack(bnk_ack), .rank_full(rank_full),
    .rank_err(rank_err), .b2x_req(b2x_req), .b2x_ba(b2x_ba), .b2x_cmd(b2x_cmd),
    .b2x_addr(b2x_addr), .b2x_id(b2x_id), .b2x_len(b2x_len),
    .b2x_start(b2x_start), .b2x_last(b2x_last), .b2x_wrap(b2x_wrap),
    .x2b_ack(x2b_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [1:0]  ba, cmd;
    logic [12:0] addr;
    logic [3:0]  id;
    logic [11:0] len;
    logic        start, last, wrap;
    logic [3:0]  ack;
    logic        full, err, st_ok;
  } exp_t;

  exp_t exp_q[$];
  int   rank_m[$];
  int   rr_m = 0;
  bit   err_m = 0;
  bit   st_ok = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int op_of(input logic [7:0] cmd, input int b);
    return int'((cmd >> (2*b)) & 8'h3);
  endfunction

  task automatic cycle(input logic rn, input logic [3:0] req, input logic [7:0] cmd,
                       input logic [3:0] r2b, input logic x2b, input logic [3:0] last);
    exp_t e;
    int g, b, lo;
    bit gv;
    @(posedge clk);
    #1;
    reset_n = rn; bnk_req = req; bnk_cmd = cmd; bnk_r2b_ack = r2b;
    x2b_ack = x2b; bnk_last = last;
    bnk_addr  = 52'({$urandom(), $urandom()});
    bnk_id    = 16'($urandom());
    bnk_len   = 48'({$urandom(), $urandom()});
    bnk_start = 4'($urandom());
    bnk_wrap  = 4'($urandom());
    gv = 0; g = 0;
    if (rn) begin
      if (rank_m.size() > 0 && req[rank_m[0]] && op_of(cmd, rank_m[0]) >= 2) begin
        gv = 1; g = rank_m[0];
      end
      for (int k = 0; k < 4 && !gv; k++) begin
        b = (rr_m + k) % 4;
        if (req[b] && op_of(cmd, b) < 2) begin gv = 1; g = b; end
      end
    end
    e.req = gv; e.ba = 2'(g); e.cmd = 2'(op_of(cmd, g));
    e.addr = 13'(bnk_addr >> (13*g)); e.id = 4'(bnk_id >> (4*g));
    e.len = 12'(bnk_len >> (12*g));
    e.start = bnk_start[g]; e.last = last[g]; e.wrap = bnk_wrap[g];
    e.ack = (gv && x2b) ? 4'(1 << g) : 4'd0;
    e.full = (rank_m.size() == 4); e.err = err_m; e.st_ok = st_ok;
    exp_q.push_back(e);
    // Model state after the coming clock edge
    if (!rn) begin
      rank_m.delete(); rr_m = 0; err_m = 0; st_ok = 1;
    end else begin
      if (gv && x2b && op_of(cmd, g) < 2) rr_m = (g + 1) % 4;
      if (gv && x2b && op_of(cmd, g) >= 2 && last[g]) void'(rank_m.pop_front());
      if (r2b != 4'd0) begin
        lo = 0;
        while (!r2b[lo]) lo++;
        if ($countones(r2b) > 1) err_m = 1;
        if (rank_m.size() < 4) rank_m.push_back(lo); else err_m = 1;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("b2x_req", 64'(b2x_req), 64'(e.req));
        chk("bnk_ack", 64'(bnk_ack), 64'(e.ack));
        if (e.req) begin
          chk("b2x_ba", 64'(b2x_ba), 64'(e.ba));
          chk("b2x_cmd", 64'(b2x_cmd), 64'(e.cmd));
          chk("b2x_addr", 64'(b2x_addr), 64'(e.addr));
          chk("b2x_id", 64'(b2x_id), 64'(e.id));
          chk("b2x_len", 64'(b2x_len), 64'(e.len));
          chk("b2x_flags", 64'({b2x_start, b2x_last, b2x_wrap}), 64'({e.start, e.last, e.wrap}));
        end
        if (e.st_ok) begin
          chk("rank_full", 64'(rank_full), 64'(e.full));
          chk("rank_err", 64'(rank_err), 64'(e.err));
        end
      end
    end
  end

  initial begin : stim
    int sel;
    logic [3:0] r2b;
    // Reset with everyone requesting, then round-robin ACT grants 0,1,2,3
    repeat (2) cycle(0, 4'hF, 8'h55, 4'h0, 1, 4'h0);
    repeat (5) cycle(1, 4'hF, 8'h55, 4'h0, 1, 4'h0);
    // Rank order 2,1: bank 2 PRE wins over non-head RD, then WR last, then RD
    cycle(1, 4'h0, 8'h00, 4'b0100, 0, 4'h0);
    cycle(1, 4'h0, 8'h00, 4'b0010, 0, 4'h0);
    cycle(1, 4'b0110, 8'h08, 4'h0, 1, 4'h0);
    cycle(1, 4'b0110, 8'h38, 4'h0, 1, 4'b0100);
    cycle(1, 4'b0010, 8'h08, 4'h0, 1, 4'b0010);
    // Head keeps on non-last chunk, pops on last, then nothing left
    cycle(1, 4'h0, 8'h00, 4'b1000, 0, 4'h0);
    cycle(1, 4'b1000, 8'h80, 4'h0, 1, 4'h0);
    cycle(1, 4'b1000, 8'h80, 4'h0, 1, 4'b1000);
    cycle(1, 4'b1000, 8'h80, 4'h0, 1, 4'b1000);
    // Fill, overflow, push+pop while full, then drain
    for (int i = 0; i < 4; i++) cycle(1, 4'h0, 8'h00, 4'(1 << i), 0, 4'h0);
    cycle(1, 4'h0, 8'h00, 4'b0001, 0, 4'h0);
    cycle(1, 4'b0001, 8'h02, 4'b0010, 1, 4'b0001);
    repeat (5) cycle(1, 4'hF, 8'hAA, 4'h0, 1, 4'hF);
    // Multi-bit accept pushes the lowest bank and flags an error
    cycle(0, 4'h0, 8'h00, 4'h0, 0, 4'h0);
    cycle(1, 4'h0, 8'h00, 4'b0110, 0, 4'h0);
    cycle(1, 4'hF, 8'hAA, 4'h0, 1, 4'hF);
    cycle(1, 4'h0, 8'h00, 4'h0, 0, 4'h0);
    // Reset with queued ranks discards them
    cycle(1, 4'h0, 8'h00, 4'b0100, 0, 4'h0);
    cycle(1, 4'h0, 8'h00, 4'b0001, 0, 4'h0);
    cycle(1, 4'h0, 8'h00, 4'b0010, 0, 4'h0);
    cycle(0, 4'h0, 8'h00, 4'h0, 0, 4'h0);
    cycle(1, 4'b0100, 8'h20, 4'h0, 1, 4'hF);
    cycle(1, 4'b0100, 8'h20, 4'h0, 1, 4'hF);
    // Random traffic
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 19));
      if (sel < 10) r2b = 4'h0;
      else if (sel < 19) r2b = 4'(1 << $urandom_range(0, 3));
      else r2b = 4'($urandom());
      cycle(($urandom_range(0, 99) != 0), 4'($urandom()), 8'($urandom()), r2b,
            ($urandom_range(0, 9) < 7), 4'($urandom()));
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
